imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//   Upstream boot stage for the monocycle RISC-V core. Consumes a byte stream
//   (valid/ready) carrying a program image and writes it into instruction memory
//   as 32-bit little-endian words. While loading, it holds the core in reset.
//   After the last word is committed it releases the core and presents the entry
//   point on initial_address.
// PARAMETERS
//   COUNT_W    16   width of the word-count header field (bytes = COUNT_W/8)
//   MAX_WORDS  256  largest accepted word count; a larger count is an error
// PORTS
//   clk              input   1   system clock, rising edge
//   reset            input   1   synchronous, active-high; re-arms loader
//   in_valid         input   1   in_data holds a valid byte
//   in_data          input   8   stream byte
//   in_ready         output  1   loader accepts a byte this cycle
//   imem_we          output  1   one-cycle instruction-memory write strobe
//   imem_addr        output  32  byte address of the write (word aligned)
//   imem_wdata       output  32  instruction word
//   core_reset       output  1   drives the monocycle reset input; 1 = held
//   initial_address  output  32  entry PC for the core; valid when done=1
//   done             output  1   image loaded, core released (sticky)
//   err              output  1   malformed header (sticky until reset)
//   words_loaded     output  COUNT_W  number of words written so far
// BEHAVIOUR
//   - Handshake: a byte transfers on a rising edge with in_valid & in_ready.
//     in_ready is combinational from state: 1 in HDR_ADDR/HDR_CNT/DATA and 0 in
//     DONE/ERROR. It is also 0 whenever reset=1.
//   - Stream format: 4 bytes start address (LSB first), then COUNT_W/8 bytes word
//     count N (LSB first), then N*4 data bytes (each word LSB first).
//   - Reset values: core_reset=1; imem_we=0; imem_addr=0; imem_wdata=0;
//     initial_address=0; done=0; err=0; words_loaded=0; state=HDR_ADDR;
//     byte index=0.
//   - FSM states:
//       HDR_ADDR: after the 4th byte, latch the address.
//                 If addr[1:0]!=0 -> ERROR; otherwise -> HDR_CNT.
//       HDR_CNT:  after the last count byte:
//                 N>MAX_WORDS -> ERROR; N==0 -> DONE; else -> DATA.
//       DATA:     every 4th byte forms a word.
//                 The next cycle: imem_we=1, imem_addr=start+4*i (mod 2^32,
//                 wraps silently), imem_wdata=word, words_loaded=i+1.
//                 After word N-1 is written -> DONE.
//       DONE:     core_reset=0, initial_address=start, done=1. Stays here
//                 until reset.
//       ERROR:    err=1, core_reset stays 1, no writes. Stays here until reset.
//   - Latency: imem_we rises on the cycle after the handshake of the word's 4th
//     byte, and lasts exactly 1 cycle. core_reset falls on the cycle after the
//     final imem_we pulse (or the cycle after the last count byte when N==0).
//     This guarantees the core never fetches before the last write.
//   - Back-pressure: in_valid gaps of any length are legal. The byte index and
//     partial word are held across gaps.
//   - in_ready stays 1 during the imem_we cycle. A byte accepted then starts
//     the next word.
//   - Bytes presented in DONE/ERROR are not accepted (in_ready=0).
//   - Reset mid-operation: all outputs return to their reset values on the next
//     edge, and core_reset=1 again. The partial header/word is discarded, and
//     the next accepted byte is address byte 0.
// TESTING
//   1. Stream start=0x00000000, N=2, words 0x00500093, 0x00100113 -> imem_we at
//      0x0 then 0x4 with those data; core_reset 1->0 one cycle after the second
//      write; initial_address=0; done=1; words_loaded=2.
//   2. Stream start=0x00000100, N=0 -> no imem_we; core_reset=0 and done=1 the
//      cycle after the last count byte; initial_address=0x100.
//   3. Stream start=0x00000102 -> err=1 after the 4th byte; in_ready=0; no
//      writes; core_reset stays 1.
//   4. Stream start=0, N=300 (> MAX_WORDS=256) -> err=1 after the count; no
//      writes.
//   5. Stream start=0xFFFFFFFC, N=2 with random 0-3 cycle in_valid gaps ->
//      writes at 0xFFFFFFFC then 0x00000000; same data as gap-free run.
//   6. Assert reset for 1 cycle after 5 of 8 data bytes, then send the full
//      stream from test 1 -> outputs reset, core_reset=1; the reload then
//      matches test 1 exactly.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot-stage loader: turns a byte stream (address, word count, payload) into
// instruction-memory writes, holding the core in reset until the image is in.
module imem_boot_loader #(
  parameter int unsigned COUNT_W   = 16,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [31:0]        imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_reset,
  output logic [31:0]        initial_address,
  output logic               done,
  output logic               err,
  output logic [COUNT_W-1:0] words_loaded
);

  localparam int unsigned CntBytes = COUNT_W / 8;
  localparam logic [7:0]  CntLast  = 8'(CntBytes - 1);

  typedef enum logic [2:0] {StHdrAddr, StHdrCnt, StData, StDone, StError} state_e;

  state_e             r_state, w_state_next;
  logic [7:0]         r_byte_idx;
  logic [31:0]        r_word, r_start;
  logic [COUNT_W-1:0] r_cnt, r_count;
  logic               r_we;
  logic [31:0]        r_addr, r_wdata;
  logic [COUNT_W-1:0] r_words_loaded;

  logic               w_xfer;
  logic [31:0]        w_word;
  logic [COUNT_W-1:0] w_cnt;
  logic               w_word_last, w_cnt_last, w_last_written;

  // Little-endian assembly: each new byte enters at the top and shifts down.
  assign w_xfer         = in_valid & in_ready;
  assign w_word         = 32'({in_data, r_word} >> 8);
  assign w_cnt          = COUNT_W'({in_data, r_cnt} >> 8);
  assign w_word_last    = (r_byte_idx == 8'd3);
  assign w_cnt_last     = (r_byte_idx == CntLast);
  assign w_last_written = r_we && (r_words_loaded == r_count);

  always_ff @(posedge clk) begin
    if (reset) r_state <= StHdrAddr;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StHdrAddr: begin
        if (w_xfer && w_word_last) begin
          w_state_next = (w_word[1:0] != 2'b00) ? StError : StHdrCnt;
        end
      end
      StHdrCnt: begin
        if (w_xfer && w_cnt_last) begin
          if (32'(w_cnt) > MAX_WORDS) w_state_next = StError;
          else if (w_cnt == '0)       w_state_next = StDone;
          else                        w_state_next = StData;
        end
      end
      // Leave DATA only once the final write strobe has been on the bus.
      StData:  if (w_last_written) w_state_next = StDone;
      default: w_state_next = r_state;
    endcase
  end

  always_comb begin
    in_ready        = !reset && (r_state == StHdrAddr || r_state == StHdrCnt ||
                                 r_state == StData);
    core_reset      = (r_state != StDone);
    done            = (r_state == StDone);
    err             = (r_state == StError);
    initial_address = (r_state == StDone) ? r_start : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx     <= 8'd0;
      r_word         <= 32'd0;
      r_start        <= 32'd0;
      r_cnt          <= '0;
      r_count        <= '0;
      r_we           <= 1'b0;
      r_addr         <= 32'd0;
      r_wdata        <= 32'd0;
      r_words_loaded <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          StHdrAddr: begin
            r_word <= w_word;
            if (w_word_last) begin
              r_byte_idx <= 8'd0;
              r_start    <= w_word;
            end else begin
              r_byte_idx <= r_byte_idx + 8'd1;
            end
          end
          StHdrCnt: begin
            r_cnt <= w_cnt;
            if (w_cnt_last) begin
              r_byte_idx <= 8'd0;
              r_count    <= w_cnt;
            end else begin
              r_byte_idx <= r_byte_idx + 8'd1;
            end
          end
          StData: begin
            r_word <= w_word;
            if (w_word_last) begin
              r_byte_idx     <= 8'd0;
              r_we           <= 1'b1;
              r_addr         <= r_start + (32'(r_words_loaded) << 2);
              r_wdata        <= w_word;
              r_words_loaded <= r_words_loaded + 1'b1;
            end else begin
              r_byte_idx <= r_byte_idx + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed and randomized images checked against an
// expected write list derived from the stream layout.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, imem_we, core_reset, done, err;
  logic [31:0] imem_addr, imem_wdata, initial_address;
  logic [15:0] words_loaded;

  imem_boot_loader #(.COUNT_W(16), .MAX_WORDS(256)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .imem_we         (imem_we),
    .imem_addr       (imem_addr),
    .imem_wdata      (imem_wdata),
    .core_reset      (core_reset),
    .initial_address (initial_address),
    .done            (done),
    .err             (err),
    .words_loaded    (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed write bus activity and core_reset release.
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          hs_q[$];
  int          fall_cyc = -1;
  int          we_double = 0;
  logic        prev_cr = 1'b1;
  logic        prev_we = 1'b0;
  int          last_hs = 0;
  int          hdr_hs = 0;
  logic [31:0] img[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
    end
    if (imem_we === 1'b1 && prev_we === 1'b1) we_double++;
    if (prev_cr === 1'b1 && core_reset === 1'b0) fall_cyc = cyc;
    prev_cr = core_reset;
    prev_we = imem_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 20 && in_ready !== 1'b1; k++) @(negedge clk);
    if (in_ready !== 1'b1) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last_hs  = cyc;
  endtask

  task automatic send_le(input logic [31:0] v, input int nbytes, input int max_gap);
    for (int i = 0; i < nbytes; i++) send_byte(v[8*i +: 8], int'($urandom_range(max_gap, 0)));
  endtask

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    wc.delete();
    hs_q.delete();
    fall_cyc  = -1;
    we_double = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic run_image(input logic [31:0] start, input int max_gap);
    send_le(start, 4, max_gap);
    send_le(32'(img.size()), 2, max_gap);
    hdr_hs = last_hs;
    for (int i = 0; i < img.size(); i++) begin
      send_le(img[i], 4, max_gap);
      hs_q.push_back(last_hs);
    end
  endtask

  task automatic wait_end();
    for (int k = 0; k < 30 && done !== 1'b1 && err !== 1'b1; k++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  // Expected: word i written at start+4*i in the cycle after its last byte;
  // core released one cycle after the final write (or after the header if empty).
  task automatic check_loaded(input string tag, input logic [31:0] start);
    int n;
    int exp_fall;
    n = img.size();
    chk({tag, "_nwrites"}, 32'(wa.size()), 32'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      chk({tag, "_addr"}, wa[i], start + 32'(4 * i));
      chk({tag, "_data"}, wd[i], img[i]);
      chk({tag, "_we_cycle"}, 32'(wc[i]), 32'(hs_q[i]));
    end
    exp_fall = (n == 0) ? hdr_hs : hs_q[n-1] + 1;
    chk({tag, "_release_cycle"}, 32'(fall_cyc), 32'(exp_fall));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    chk({tag, "_init_addr"}, initial_address, start);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(n));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_we_single"}, 32'(we_double), 32'd0);
  endtask

  task automatic check_error(input string tag);
    chk({tag, "_err"}, 32'(err), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_nwrites"}, 32'(wa.size()), 32'd0);
    chk({tag, "_init_addr"}, initial_address, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_init_addr"}, initial_address, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    logic [31:0] start;

    // Reset state, in_ready forced low while reset is high.
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 32'(in_ready), 32'd1);
    clear_mon();

    // Two-word image at address 0.
    img = '{32'h00500093, 32'h00100113};
    run_image(32'h0, 0);
    wait_end();
    check_loaded("t1", 32'h0);

    // Empty image releases right after the header.
    do_reset();
    check_reset_vals("t2_pre");
    img.delete();
    run_image(32'h00000100, 0);
    wait_end();
    check_loaded("t2", 32'h00000100);

    // Misaligned start address.
    do_reset();
    send_le(32'h00000102, 4, 0);
    chk("t3_err_now", 32'(err), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_error("t3");

    // Oversized count, one-past-limit count.
    do_reset();
    send_le(32'h0, 4, 0);
    send_le(32'd300, 2, 0);
    chk("t4_err_now", 32'(err), 32'd1);
    repeat (2) @(negedge clk);
    check_error("t4");

    do_reset();
    send_le(32'h0, 4, 0);
    send_le(32'd257, 2, 0);
    repeat (2) @(negedge clk);
    check_error("t4b");

    // Largest accepted image.
    do_reset();
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back($urandom);
    run_image(32'h00001000, 0);
    wait_end();
    check_loaded("max", 32'h00001000);

    // Address wrap with random valid gaps.
    do_reset();
    img = '{$urandom, $urandom};
    run_image(32'hFFFFFFFC, 3);
    wait_end();
    check_loaded("t5", 32'hFFFFFFFC);

    // Reset in the middle of the second word, then a clean reload.
    do_reset();
    img = '{32'h00500093, 32'h00100113};
    send_le(32'h0, 4, 0);
    send_le(32'd2, 2, 0);
    send_le(img[0], 4, 0);
    send_byte(img[1][7:0], 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("t6_mid");
    chk("t6_mid_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    run_image(32'h0, 0);
    wait_end();
    check_loaded("t6", 32'h0);

    // Random aligned images with random gaps.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      start = {$urandom} & 32'hFFFFFFFC;
      img.delete();
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) img.push_back($urandom);
      run_image(start, 2);
      wait_end();
      check_loaded("rnd", start);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
